run_monitor: RTL and testbench

- Synthesizable run supervisor for the pipelined CPU. It replaces the ad-hoc cycle, stall and finish logic that currently lives in the bench.
- Counts cycles, stall cycles and retired instructions, then detects the finish store to a configurable address.
- Enforces a cycle timeout.
- After finish or timeout it streams a configurable window of data memory out through a valid/ready port.
- Sits beside the CPU core, snooping the data-memory bus and sharing a read port into dmem.

---
 rtl/run_monitor_pkg.sv | 22 ++
 rtl/run_monitor_sat_counter.sv | 20 ++
 rtl/run_monitor.sv | 150 +++++++++++++++
 tb/tb_run_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run supervisor: state encodings, default addresses, enable levels.
// RUN_MONITOR_WATCH_EN adds the default watch address.
package run_monitor_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [31:0] DEF_FINISH_ADDR = 32'h80;
`ifdef RUN_MONITOR_WATCH_EN
    localparam logic [31:0] DEF_WATCH_ADDR = 32'h7C;
`endif

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DUMP_RD  = 2'd1,
        ST_DUMP_OUT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by async reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run supervisor: counts cycles/stalls/retires, ends on finish store or timeout, then streams dmem.
// Optional RUN_MONITOR_WATCH_EN counts stores to WATCH_ADDR.
//
// state       | meaning
// ST_RUN      | counting; watching for finish store or cycle limit
// ST_DUMP_RD  | dump_addr presents index, dmem word captured next edge
// ST_DUMP_OUT | dump word valid, waiting for dump_ready
// ST_DONE     | dump finished; terminal until reset
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                CNT_W       = 32,
    parameter logic [DATA_W-1:0] FINISH_ADDR = DATA_W'(DEF_FINISH_ADDR),
    parameter int                MAX_CYCLES  = 100,
    parameter int                DUMP_WORDS  = 50,
    parameter int                IDX_W       = 16
`ifdef RUN_MONITOR_WATCH_EN
    ,
    parameter logic [DATA_W-1:0] WATCH_ADDR  = DATA_W'(DEF_WATCH_ADDR)
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              retire,
    input  logic [DATA_W-1:0] daddr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [DATA_W-1:0] finish_data,
    output logic              timeout,
    output logic [IDX_W-1:0]  dump_addr,
    input  logic [DATA_W-1:0] dump_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [IDX_W-1:0]  dump_idx,
    output logic              done,
    output logic [CNT_W-1:0]  watch_cnt
);

    // Compare in at least 32 bits so a narrow counter cannot alias the limit.
    localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [CMP_W-1:0] LAST_CYCLE = CMP_W'($unsigned(MAX_CYCLES - 1));
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'($unsigned(DUMP_WORDS - 1));

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             finish_hit;
    logic             timeout_hit;
    logic             cnt_en;

    assign finish_hit  = we && (daddr == FINISH_ADDR);
    assign timeout_hit = (CMP_W'(cycle_cnt) == LAST_CYCLE);
    assign cnt_en      = (state == ST_RUN) && !finish_hit;
    assign dump_addr   = idx;

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .inc   (ENABLE),
        .q     (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .inc   (stall),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .inc   (retire),
        .q     (retire_cnt)
    );

`ifdef RUN_MONITOR_WATCH_EN
    logic watch_hit;
    assign watch_hit = we && (daddr == WATCH_ADDR);

    sat_counter #(.W(CNT_W)) u_watch (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .inc   (watch_hit),
        .q     (watch_cnt)
    );
`else
    assign watch_cnt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            idx         <= '0;
            finish_data <= '0;
            timeout     <= DISABLE;
            dump_valid  <= DISABLE;
            dump_data   <= '0;
            dump_idx    <= '0;
            done        <= DISABLE;
        end else begin
            case (state)
                ST_RUN: begin
                    // Finish takes priority over a timeout landing in the same cycle.
                    if (finish_hit) begin
                        finish_data <= wdata;
                        state       <= ST_DUMP_RD;
                    end else if (timeout_hit) begin
                        timeout <= ENABLE;
                        state   <= ST_DUMP_RD;
                    end
                end
                ST_DUMP_RD: begin
                    dump_data  <= dump_rdata;
                    dump_idx   <= idx;
                    dump_valid <= ENABLE;
                    state      <= ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    if (dump_ready) begin
                        dump_valid <= DISABLE;
                        if (idx == LAST_IDX) begin
                            done  <= ENABLE;
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_DUMP_RD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: counters, finish/timeout, backpressured dump, saturation, reset abort.
module tb_run_monitor;

    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] idx;
    } dump_exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall, retire, we;
    logic [31:0] daddr, wdata;
    logic [31:0] cycle_cnt, stall_cnt, retire_cnt, finish_data, watch_cnt;
    logic        timeout, dump_valid, dump_ready, done;
    logic [15:0] dump_addr, dump_idx;
    logic [31:0] dump_rdata, dump_data;

    logic        sat_rst_n, sat_stall;
    logic [3:0]  sat_cycle, sat_stall_cnt, sat_retire, sat_watch;
    logic [31:0] sat_finish, sat_rdata, sat_ddata;
    logic        sat_timeout, sat_valid, sat_done;
    logic [15:0] sat_addr, sat_didx;

    logic [31:0] mem [16];
    dump_exp_t   sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc_cnt = 0;

    assign dump_rdata = mem[dump_addr[3:0]];
    assign sat_rdata  = mem[sat_addr[3:0]];

    run_monitor #(.MAX_CYCLES(20), .DUMP_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .retire(retire),
        .daddr(daddr), .we(we), .wdata(wdata),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt),
        .finish_data(finish_data), .timeout(timeout), .dump_addr(dump_addr),
        .dump_rdata(dump_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_idx(dump_idx), .done(done), .watch_cnt(watch_cnt)
    );

    run_monitor #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(sat_rst_n), .stall(sat_stall), .retire(1'b0),
        .daddr(32'h0), .we(1'b0), .wdata(32'h0),
        .cycle_cnt(sat_cycle), .stall_cnt(sat_stall_cnt), .retire_cnt(sat_retire),
        .finish_data(sat_finish), .timeout(sat_timeout), .dump_addr(sat_addr),
        .dump_rdata(sat_rdata), .dump_valid(sat_valid), .dump_ready(1'b1),
        .dump_data(sat_ddata), .dump_idx(sat_didx), .done(sat_done), .watch_cnt(sat_watch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Backpressure: ready alternates every cycle.
    initial begin
        dump_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            dump_ready = ~dump_ready;
        end
    end

    // Scoreboard monitor: every valid cycle must show the head word; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && dump_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                check("dump_data", dump_data, sb_q[0].data);
                check("dump_idx", dump_idx, sb_q[0].idx);
                if (dump_ready) begin
                    void'(sb_q.pop_front());
                    acc_cnt++;
                end
            end
        end
    end

    task automatic push_dump();
        for (int i = 0; i < 4; i++) sb_q.push_back('{data: 32'h100 + i, idx: 16'(i)});
        acc_cnt = 0;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; retire = 1'b0; we = 1'b0; daddr = '0; wdata = '0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cycle"}, cycle_cnt, 0);
        check({tag, "_stall"}, stall_cnt, 0);
        check({tag, "_retire"}, retire_cnt, 0);
        check({tag, "_finish"}, finish_data, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_valid"}, dump_valid, 0);
        check({tag, "_ddata"}, dump_data, 0);
        check({tag, "_didx"}, dump_idx, 0);
        check({tag, "_daddr"}, dump_addr, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_zero("rst");
        sb_q.delete();
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; daddr = a; wdata = d;
        tick(1);
        idle_inputs();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done", done, 1);
        @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        check("accepted", acc_cnt, 4);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        idle_inputs();
        rst_n = 1'b0;
        sat_rst_n = 1'b0;
        sat_stall = 1'b0;

        // Saturation on a 4-bit instance
        tick(1);
        sat_rst_n = 1'b1;
        sat_stall = 1'b1;
        tick(20);
        check("sat_stall", sat_stall_cnt, 4'hF);
        check("sat_cycle", sat_cycle, 4'hF);
        check("sat_timeout", sat_timeout, 0);

        // Finish store after 10 cycles
        do_reset();
        for (int c = 0; c < 10; c++) begin
            stall = (c < 3); retire = (c < 6);
            tick(1);
        end
        idle_inputs();
        push_dump();
        store(32'h80, 32'hDEADBEEF);
        check("fin_cycle", cycle_cnt, 10);
        check("fin_stall", stall_cnt, 3);
        check("fin_retire", retire_cnt, 6);
        check("fin_data", finish_data, 32'hDEADBEEF);
        check("fin_timeout", timeout, 0);
        wait_done();

        // Timeout at MAX_CYCLES=20
        do_reset();
        push_dump();
        tick(19);
        check("to_pre", timeout, 0);
        check("to_pre_cycle", cycle_cnt, 19);
        tick(1);
        check("to_flag", timeout, 1);
        check("to_cycle", cycle_cnt, 20);
        wait_done();
        // DONE ignores bus activity
        stall = 1'b1; retire = 1'b1; we = 1'b1; daddr = 32'h80; wdata = 32'h5;
        tick(3);
        idle_inputs();
        check("dn_cycle", cycle_cnt, 20);
        check("dn_finish", finish_data, 0);
        check("dn_done", done, 1);
        check("dn_valid", dump_valid, 0);

        // Finish store coinciding with the timeout cycle
        do_reset();
        tick(19);
        push_dump();
        store(32'h80, 32'hCAFE);
        check("tie_timeout", timeout, 0);
        check("tie_cycle", cycle_cnt, 19);
        check("tie_data", finish_data, 32'hCAFE);
        wait_done();

        // Reset during DUMP_OUT at index 2
        do_reset();
        push_dump();
        store(32'h80, 32'h1);
        begin
            int n = 0;
            while (!(dump_valid && dump_idx == 16'd2) && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("mid_reach", dump_idx, 2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid");
        sb_q.delete();
        tick(1);
        rst_n = 1'b1;
        push_dump();
        tick(2);
        store(32'h80, 32'h2);
        check("rerun_cycle", cycle_cnt, 2);
        wait_done();

        // Watch stores
        do_reset();
        push_dump();
        store(32'h7C, 32'h11);
        tick(1);
        store(32'h7C, 32'h12);
        store(32'h7C, 32'h13);
        store(32'h80, 32'h99);
`ifdef RUN_MONITOR_WATCH_EN
        check("watch_cnt", watch_cnt, 3);
`else
        check("watch_cnt", watch_cnt, 0);
`endif
        check("watch_cycle", cycle_cnt, 4);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
